// File: rtl/rx_check_defs.sv
// Shared definitions for the egress packet checker: header field offsets,
// error-bit indices, FSM encoding and the payload pattern generator.
package rx_check_defs;

    localparam int N_ERR      = 6;
    localparam int ERR_DEST   = 0;
    localparam int ERR_LEN    = 1;
    localparam int ERR_DATA   = 2;
    localparam int ERR_SOP    = 3;
    localparam int ERR_ORPHAN = 4;
    localparam int ERR_RDY    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BODY  = 2'd1,
        ST_DRAIN = 2'd2
    } rx_state_t;

    // Header layout LSB up: length, priority, dest, src.
    function automatic int dest_lsb(input int width_length, input int width_priority);
        return width_length + width_priority;
    endfunction

    // Payload beat k carries the low header half above the beat index.
    function automatic logic [31:0] payload_word(input logic [15:0] hdr_lo, input logic [15:0] idx);
        return {hdr_lo, idx};
    endfunction

endpackage

// File: rtl/rx_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module rx_sat_counter #(
    parameter int WIDTH     = 16,
    parameter int INC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [INC_WIDTH-1:0] inc,
    output logic [WIDTH-1:0]     count
);

    logic [WIDTH:0] sum_s;

    assign sum_s = {1'b0, count} + (WIDTH + 1)'(inc);

    // Count register: sticks at all-ones once the carry bit is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (sum_s[WIDTH]) begin
            count <= '1;
        end else begin
            count <= sum_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/receive_module.sv
// Per-port egress packet sink: parses header, checks dest/length/payload
// pattern and keeps saturating good/error statistics.
module receive_module
    import rx_check_defs::*;
#(
    parameter int RX_PORT    = 0,
    parameter int PORT_NUB   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LENGTH_MAX = 256,
    parameter int PRIORITY   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_sop,
    input  logic                  rd_eop,
    input  logic                  rd_vld,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  stall,
    input  logic                  clear,
    output logic                  ready,
    output logic                  pkt_done,
    output logic                  pkt_ok,
    output logic [31:0]           pkt_cnt,
    output logic [15:0]           err_cnt,
    output logic [N_ERR-1:0]      err_flags,
    output logic                  busy
);

    localparam int WIDTH_SEL      = $clog2(PORT_NUB);
    localparam int WIDTH_LENGTH   = $clog2(LENGTH_MAX);
    localparam int WIDTH_PRIORITY = $clog2(PRIORITY);
    localparam int DEST_LSB       = dest_lsb(WIDTH_LENGTH, WIDTH_PRIORITY);
    localparam logic [WIDTH_SEL-1:0]    RX_DEST = WIDTH_SEL'(RX_PORT);
    localparam logic [WIDTH_LENGTH-1:0] IDX_ONE = WIDTH_LENGTH'(1);
    localparam logic [WIDTH_LENGTH:0]   LEN_ONE = (WIDTH_LENGTH + 1)'(1);

    rx_state_t               state_r, state_nx_s;
    logic [WIDTH_LENGTH-1:0] idx_r, idx_nx_s, len_r, len_nx_s, in_len_s;
    logic [15:0]             hdr_r, hdr_nx_s;
    logic [N_ERR-1:0]        perr_r, perr_nx_s, hdr_err_s, body_err_s, flag_set_s, flags_r;
    logic [DATA_WIDTH-1:0]   exp_beat_s;
    logic                    data_bad_s, done_s, ok_s, good_s;
    logic [1:0]              bad_s;
    logic                    ready_r, pkt_done_r, pkt_ok_r;

    assign in_len_s   = rd_data[WIDTH_LENGTH-1:0];
    assign exp_beat_s = DATA_WIDTH'(payload_word(hdr_r, 16'(idx_r)));
    assign data_bad_s = (rd_data != exp_beat_s);

    // Error vectors for the incoming header and for the current payload beat.
    always_comb begin
        hdr_err_s             = '0;
        hdr_err_s[ERR_DEST]   = (rd_data[DEST_LSB +: WIDTH_SEL] != RX_DEST);
        hdr_err_s[ERR_LEN]    = (in_len_s != '0);
        body_err_s            = perr_r;
        body_err_s[ERR_DATA]  = perr_r[ERR_DATA] | ((idx_r < len_r) & data_bad_s);
        body_err_s[ERR_LEN]   = perr_r[ERR_LEN] |
                                (rd_eop & (({1'b0, idx_r} + LEN_ONE) != {1'b0, len_r}));
    end

    // Next-state, termination and statistics-increment decode.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        len_nx_s   = len_r;
        hdr_nx_s   = hdr_r;
        perr_nx_s  = perr_r;
        done_s     = 1'b0;
        ok_s       = 1'b1;
        good_s     = 1'b0;
        bad_s      = 2'd0;
        flag_set_s = '0;
        flag_set_s[ERR_RDY] = rd_vld & ~ready_r;
        if (rd_vld && rd_sop) begin
            // A new header mid-packet closes the old packet as bad first.
            if (state_r != ST_IDLE) begin
                done_s              = 1'b1;
                ok_s                = 1'b0;
                bad_s               = 2'd1;
                flag_set_s          = flag_set_s | perr_r;
                flag_set_s[ERR_SOP] = 1'b1;
            end else begin
                bad_s = 2'd0;
            end
            hdr_nx_s = rd_data[15:0];
            len_nx_s = in_len_s;
            idx_nx_s = '0;
            if (rd_eop) begin
                done_s     = 1'b1;
                state_nx_s = ST_IDLE;
                perr_nx_s  = '0;
                flag_set_s = flag_set_s | hdr_err_s;
                if (hdr_err_s == '0) begin
                    good_s = 1'b1;
                end else begin
                    bad_s = bad_s + 2'd1;
                    ok_s  = 1'b0;
                end
            end else begin
                state_nx_s          = ST_BODY;
                perr_nx_s           = '0;
                perr_nx_s[ERR_DEST] = hdr_err_s[ERR_DEST];
            end
        end else if (rd_vld) begin
            case (state_r)
                ST_IDLE: begin
                    flag_set_s[ERR_ORPHAN] = 1'b1;
                    bad_s                  = 2'd1;
                end
                ST_BODY: begin
                    if (rd_eop) begin
                        done_s     = 1'b1;
                        state_nx_s = ST_IDLE;
                        flag_set_s = flag_set_s | body_err_s;
                        if (body_err_s == '0) begin
                            good_s = 1'b1;
                        end else begin
                            bad_s = 2'd1;
                            ok_s  = 1'b0;
                        end
                    end else if (idx_r == len_r) begin
                        state_nx_s         = ST_DRAIN;
                        perr_nx_s          = body_err_s;
                        perr_nx_s[ERR_LEN] = 1'b1;
                    end else begin
                        perr_nx_s = body_err_s;
                        idx_nx_s  = idx_r + IDX_ONE;
                    end
                end
                ST_DRAIN: begin
                    // Overrun already flagged LEN, so the drained packet is always bad.
                    if (rd_eop) begin
                        done_s     = 1'b1;
                        ok_s       = 1'b0;
                        bad_s      = 2'd1;
                        state_nx_s = ST_IDLE;
                        flag_set_s = flag_set_s | perr_r;
                    end else begin
                        state_nx_s = ST_DRAIN;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // FSM state and per-packet context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            len_r   <= '0;
            hdr_r   <= '0;
            perr_r  <= '0;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            len_r   <= len_nx_s;
            hdr_r   <= hdr_nx_s;
            perr_r  <= perr_nx_s;
        end
    end

    // Registered status outputs and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r    <= 1'b0;
            pkt_done_r <= 1'b0;
            pkt_ok_r   <= 1'b0;
            flags_r    <= '0;
        end else begin
            ready_r    <= ~stall;
            pkt_done_r <= done_s;
            pkt_ok_r   <= done_s & ok_s;
            flags_r    <= clear ? '0 : (flags_r | flag_set_s);
        end
    end

    rx_sat_counter #(.WIDTH(32), .INC_WIDTH(1)) u_pkt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (good_s),
        .count (pkt_cnt)
    );

    rx_sat_counter #(.WIDTH(16), .INC_WIDTH(2)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (bad_s),
        .count (err_cnt)
    );

    assign ready     = ready_r;
    assign pkt_done  = pkt_done_r;
    assign pkt_ok    = pkt_ok_r;
    assign err_flags = flags_r;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_receive_module.sv
// Self-checking bench for receive_module: directed scenarios plus randomized
// packet streams checked against a whole-packet behavioural model.
module tb_receive_module;

    localparam int RX = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_sop = 1'b0, rd_eop = 1'b0, rd_vld = 1'b0;
    logic [31:0] rd_data = '0;
    logic        stall = 1'b0, clear = 1'b0;
    logic        ready, pkt_done, pkt_ok, busy;
    logic [31:0] pkt_cnt;
    logic [15:0] err_cnt;
    logic [5:0]  err_flags;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0] q[$];
    bit          in_pkt = 1'b0;
    bit          stall_q = 1'b1;
    longint      exp_pkt = 0;
    longint      exp_err = 0;
    logic [5:0]  exp_flags = '0;
    bit          exp_done = 1'b0, exp_ok = 1'b0;

    always #5 clk = ~clk;

    receive_module #(.RX_PORT(RX)) dut (
        .clk(clk), .rst(rst), .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld),
        .rd_data(rd_data), .stall(stall), .clear(clear), .ready(ready),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
        .err_flags(err_flags), .busy(busy)
    );

    // Judge a collected packet (header followed by payloads) as a whole.
    function automatic logic [5:0] eval_pkt(input logic [31:0] b[$], input bit complete);
        logic [5:0]  e = '0;
        logic [31:0] h = b[0];
        int          len = int'(h[7:0]);
        int          n = b.size() - 1;
        e[0] = (h[12:11] != 2'(RX));
        for (int k = 0; k < n; k++) begin
            if (k < len && b[k+1] !== {h[15:0], 16'(k)}) e[2] = 1'b1;
        end
        e[1] = complete ? (n != len) : (n > len);
        return e;
    endfunction

    function automatic void model_reset();
        q.delete();
        in_pkt = 1'b0; exp_pkt = 0; exp_err = 0; exp_flags = '0;
        exp_done = 1'b0; exp_ok = 1'b0;
    endfunction

    // Drive one clock cycle of input, advance the model, sample 1 ns after the edge.
    task automatic beat(input bit v, input bit s, input bit e, input logic [31:0] d,
                        input bit stl, input bit clr);
        int n_good = 0, n_bad = 0, n_term = 0;
        logic [5:0] ev, fl;
        fl = '0;
        @(negedge clk);
        rd_vld = v; rd_sop = s; rd_eop = e; rd_data = d; stall = stl; clear = clr;
        if (v && stall_q) fl[5] = 1'b1;
        if (v && s) begin
            if (in_pkt) begin
                ev = eval_pkt(q, 1'b0);
                n_bad++; n_term++; fl = fl | ev; fl[3] = 1'b1;
            end
            q.delete(); q.push_back(d); in_pkt = 1'b1;
        end else if (v && in_pkt) begin
            q.push_back(d);
        end else if (v) begin
            n_bad++; fl[4] = 1'b1;
        end
        if (v && e && in_pkt) begin
            ev = eval_pkt(q, 1'b1);
            n_term++;
            if (ev == 0) n_good++; else n_bad++;
            fl = fl | ev; in_pkt = 1'b0; q.delete();
        end
        exp_done  = (n_term > 0);
        exp_ok    = (n_term > 0) && (n_good == n_term);
        exp_pkt   = (exp_pkt + n_good > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : exp_pkt + n_good;
        exp_err   = (exp_err + n_bad > 65535) ? 65535 : exp_err + n_bad;
        exp_flags = exp_flags | fl;
        if (clr) begin
            exp_pkt = 0; exp_err = 0; exp_flags = '0;
        end
        stall_q = stl;
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit clr);
        beat(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, clr);
    endtask

    task automatic test_reset();
        #1;
        @(posedge clk); #1;
        n_checks++;
        if ({ready, pkt_done, pkt_ok, busy, err_flags, err_cnt, pkt_cnt} !== 58'h0) begin
            n_fail++;
            $display("FAIL reset.outputs got rdy=%b done=%b ok=%b busy=%b flags=%b err=%0d pkt=%0d, expected all 0",
                     ready, pkt_done, pkt_ok, busy, err_flags, err_cnt, pkt_cnt);
        end
        @(negedge clk); rst = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset.ready_after got %b expected 1", ready); end
        model_reset(); stall_q = 1'b0;
    endtask

    task automatic test_good_packet();
        logic [31:0] pkt[4] = '{32'h0000_1503, 32'h1503_0000, 32'h1503_0001, 32'h1503_0002};
        idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, i == 0, i == 3, pkt[i], 1'b0, 1'b0);
            n_checks++;
            if (pkt_done !== (i == 3)) begin
                n_fail++; $display("FAIL good.pkt_done beat %0d got %b expected %b", i, pkt_done, i == 3);
            end
        end
        n_checks++;
        if (pkt_ok !== 1'b1) begin n_fail++; $display("FAIL good.pkt_ok got %b expected 1", pkt_ok); end
        n_checks++;
        if (pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL good.pkt_cnt got %0d expected 1", pkt_cnt); end
        n_checks++;
        if (err_flags !== 6'b0) begin n_fail++; $display("FAIL good.err_flags got %b expected 0", err_flags); end
        idle(1'b0);
        n_checks++;
        if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL good.done_pulse got %b expected 0", pkt_done); end
    endtask

    task automatic test_bad_dest();
        logic [31:0] pkt[4] = '{32'h0000_0D03, 32'h0D03_0000, 32'h0D03_0001, 32'h0D03_0002};
        idle(1'b1);
        for (int i = 0; i < 4; i++) beat(1'b1, i == 0, i == 3, pkt[i], 1'b0, 1'b0);
        n_checks++;
        if ({pkt_done, pkt_ok} !== 2'b10) begin
            n_fail++; $display("FAIL dest.done_ok got %b%b expected 10", pkt_done, pkt_ok);
        end
        n_checks++;
        if (err_flags !== 6'b000001) begin n_fail++; $display("FAIL dest.err_flags got %b expected 000001", err_flags); end
        n_checks++;
        if ({err_cnt, pkt_cnt} !== {16'd1, 32'd0}) begin
            n_fail++; $display("FAIL dest.counts got err=%0d pkt=%0d expected err=1 pkt=0", err_cnt, pkt_cnt);
        end
    endtask

    task automatic test_len_data();
        logic [31:0] a[3] = '{32'h0000_1503, 32'h1503_0000, 32'h1503_0001};
        logic [31:0] b[3] = '{32'h0000_1502, 32'h1502_0000, 32'h0000_0000};
        idle(1'b1);
        for (int i = 0; i < 3; i++) beat(1'b1, i == 0, i == 2, a[i], 1'b0, 1'b0);
        n_checks++;
        if (err_flags !== 6'b000010) begin n_fail++; $display("FAIL len.err_flags got %b expected 000010", err_flags); end
        for (int i = 0; i < 3; i++) beat(1'b1, i == 0, i == 2, b[i], 1'b0, 1'b0);
        n_checks++;
        if (err_flags !== 6'b000110) begin n_fail++; $display("FAIL data.err_flags got %b expected 000110", err_flags); end
        n_checks++;
        if ({err_cnt, pkt_cnt} !== {16'd2, 32'd0}) begin
            n_fail++; $display("FAIL lendata.counts got err=%0d pkt=%0d expected err=2 pkt=0", err_cnt, pkt_cnt);
        end
    endtask

    task automatic test_sop_abort();
        idle(1'b1);
        beat(1'b1, 1'b1, 1'b0, 32'h0000_1503, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 32'h1503_0000, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 1'b0);
        n_checks++;
        if ({pkt_done, busy} !== 2'b10) begin n_fail++; $display("FAIL abort.done_busy got %b%b expected 10", pkt_done, busy); end
        n_checks++;
        if (err_flags !== 6'b001000) begin n_fail++; $display("FAIL abort.err_flags got %b expected 001000", err_flags); end
        n_checks++;
        if ({pkt_cnt, err_cnt} !== {32'd1, 16'd1}) begin
            n_fail++; $display("FAIL abort.counts got pkt=%0d err=%0d expected pkt=1 err=1", pkt_cnt, err_cnt);
        end
    endtask

    task automatic test_orphan_stall();
        idle(1'b1);
        beat(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b1, 32'h0000_1502, 1'b0, 1'b0);
        n_checks++;
        if ({err_cnt, err_flags, busy} !== {16'd2, 6'b010000, 1'b0}) begin
            n_fail++; $display("FAIL orphan.state got err=%0d flags=%b busy=%b expected err=2 flags=010000 busy=0", err_cnt, err_flags, busy);
        end
        beat(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL stall.ready got %b expected 0", ready); end
        beat(1'b1, 1'b1, 1'b0, 32'h0000_1502, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 32'h1502_0000, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b1, 32'h1502_0001, 1'b1, 1'b0);
        n_checks++;
        if ({pkt_done, pkt_ok, pkt_cnt, err_cnt} !== {2'b11, 32'd1, 16'd2}) begin
            n_fail++; $display("FAIL stall.pkt got done=%b ok=%b pkt=%0d err=%0d expected 1 1 1 2", pkt_done, pkt_ok, pkt_cnt, err_cnt);
        end
        n_checks++;
        if (err_flags !== 6'b110000) begin n_fail++; $display("FAIL stall.err_flags got %b expected 110000", err_flags); end
        idle(1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] s[6] = '{32'h0000_1001, 32'h1001_0000, 32'h0000_1000,
                              32'h0000_1002, 32'h1002_0000, 32'h1002_0001};
        bit          sp[6] = '{1, 0, 1, 1, 0, 0};
        bit          ep[6] = '{0, 1, 1, 0, 0, 1};
        idle(1'b1);
        for (int i = 0; i < 6; i++) begin
            beat(1'b1, sp[i], ep[i], s[i], 1'b0, 1'b0);
            n_checks++;
            if ({pkt_done, pkt_ok} !== {ep[i], ep[i]}) begin
                n_fail++; $display("FAIL b2b.done_ok beat %0d got %b%b expected %b%b", i, pkt_done, pkt_ok, ep[i], ep[i]);
            end
        end
        n_checks++;
        if ({pkt_cnt, err_cnt} !== {32'd3, 16'd0}) begin
            n_fail++; $display("FAIL b2b.counts got pkt=%0d err=%0d expected pkt=3 err=0", pkt_cnt, err_cnt);
        end
    endtask

    task automatic test_clear_rst();
        idle(1'b1);
        beat(1'b1, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b0, 32'h0000_1501, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b1, 32'h1501_0000, 1'b0, 1'b1);
        n_checks++;
        if ({pkt_cnt, err_cnt, err_flags} !== 54'h0) begin
            n_fail++; $display("FAIL clear.counts got pkt=%0d err=%0d flags=%b expected 0", pkt_cnt, err_cnt, err_flags);
        end
        beat(1'b1, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b0, 32'h0000_1503, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 32'h1503_0000, 1'b0, 1'b0);
        n_checks++;
        if ({busy, pkt_cnt} !== {1'b1, 32'd1}) begin
            n_fail++; $display("FAIL rst.before got busy=%b pkt=%0d expected busy=1 pkt=1", busy, pkt_cnt);
        end
        @(negedge clk);
        rst = 1'b1; rd_vld = 1'b0; #1;
        n_checks++;
        if ({busy, ready, pkt_done, pkt_cnt, err_cnt} !== 51'h0) begin
            n_fail++; $display("FAIL rst.async got busy=%b rdy=%b done=%b pkt=%0d err=%0d expected 0", busy, ready, pkt_done, pkt_cnt, err_cnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL rst.ready_held got %b expected 0", ready); end
        @(negedge clk); rst = 1'b0; stall = 1'b0;
        model_reset(); stall_q = 1'b0;
    endtask

    task automatic test_random();
        int          nb, len, m;
        logic [31:0] hdr;
        bit          stl;
        for (int p = 0; p < 60; p++) begin
            m   = $urandom_range(0, 9);
            len = $urandom_range(0, 6);
            hdr = 32'(($urandom_range(0, 3) << 13) |
                      ((($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : RX) << 11) |
                      ($urandom_range(0, 7) << 8) | len);
            nb  = (m == 5) ? $urandom_range(0, 8) : (m == 7) ? $urandom_range(0, len + 2) : len;
            stl = (m == 9);
            for (int g = $urandom_range(0, 2); g > 0; g--)
                beat(1'b0, 1'($urandom), 1'($urandom), $urandom, stl, $urandom_range(0, 24) == 0);
            if (m == 8 && !in_pkt) beat(1'b1, 1'b0, 1'($urandom), $urandom, stl, 1'b0);
            for (int i = 0; i <= nb; i++) begin
                logic [31:0] d;
                d = (i == 0) ? hdr : {hdr[15:0], 16'(i - 1)};
                if (m == 6 && i == nb && i > 0) d = d ^ (32'd1 << $urandom_range(0, 31));
                beat(1'b1, i == 0, (i == nb) && (m != 7), d, stl, $urandom_range(0, 24) == 0);
                n_checks++;
                if ({pkt_done, pkt_ok} !== {exp_done, exp_done && exp_ok}) begin
                    n_fail++; $display("FAIL rand.done_ok pkt %0d beat %0d got %b%b expected %b%b", p, i, pkt_done, pkt_ok, exp_done, exp_done && exp_ok);
                end
                n_checks++;
                if ({pkt_cnt, err_cnt} !== {32'(exp_pkt), 16'(exp_err)}) begin
                    n_fail++; $display("FAIL rand.counts pkt %0d beat %0d got pkt=%0d err=%0d expected pkt=%0d err=%0d", p, i, pkt_cnt, err_cnt, exp_pkt, exp_err);
                end
                n_checks++;
                if ({err_flags, busy, ready} !== {exp_flags, in_pkt, ~stall_q}) begin
                    n_fail++; $display("FAIL rand.flags pkt %0d beat %0d got flags=%b busy=%b rdy=%b expected flags=%b busy=%b rdy=%b", p, i, err_flags, busy, ready, exp_flags, in_pkt, ~stall_q);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_dest();
        test_len_data();
        test_sop_abort();
        test_orphan_stall();
        test_back_to_back();
        test_clear_rst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/receive_module.md
# receive_module

Per-port packet sink and checker for the NxN switch egress side. It consumes one output port's `rd_sop/rd_eop/rd_vld/rd_data` stream and drives that port's `ready`. It parses the header beat, checks destination, length and payload pattern against the format `send_module` generates, and keeps saturating good/error statistics for the on-chip debug probes. One instance is placed per egress port, alongside the per-port `send_module` instances.

## Interface
- `RX_PORT`, 0: port index this instance is attached to; the expected header `dest`.
- `PORT_NUB`, 4: number of switch ports; `WIDTH_SEL = $clog2(PORT_NUB)`.
- `DATA_WIDTH`, 32: beat width; must be ≥ 32; bits above 31 are always expected to be 0.
- `LENGTH_MAX`, 256: maximum payload beats; `WIDTH_LENGTH = $clog2(LENGTH_MAX)`.
- `PRIORITY`, 8: priority levels; `WIDTH_PRIORITY = $clog2(PRIORITY)`.
- `clk` in, 1: single clock for the whole block.
- `rst` in, 1: **one clock; reset is asynchronous and active-high.**
- `rd_sop` in, 1: first beat of a packet; qualified by `rd_vld`.
- `rd_eop` in, 1: last beat of a packet; qualified by `rd_vld`.
- `rd_vld` in, 1: beat valid.
- `rd_data` in, DATA_WIDTH: beat data.
- `stall` in, 1: test throttle; deasserts `ready`.
- `clear` in, 1: synchronous clear of all counters and flags.
- `ready` out, 1: registered; `~stall`; reset value 0.
- `pkt_done` out, 1: one-cycle pulse per terminated packet; reset value 0.
- `pkt_ok` out, 1: valid with `pkt_done`; 1 means the packet had no errors; reset value 0.
- `pkt_cnt` out, 32: count of good packets; saturates at all-ones; reset value 0.
- `err_cnt` out, 16: count of erroneous packets plus orphan beats; saturating; reset value 0.
- `err_flags` out, 6: sticky error bits; reset value 0.
- `busy` out, 1: 1 when the FSM is not in IDLE.

## Operation
- **Header beat layout** (beat with `sop`), LSB up:
  - `length` [WIDTH_LENGTH-1:0] (payload beats, 0..LENGTH_MAX-1)
  - `priority` [WIDTH_PRIORITY]
  - `dest` [WIDTH_SEL]
  - `src` [WIDTH_SEL]
  - Defaults give len[7:0], pri[10:8], dest[12:11], src[14:13].
- **Payload:** beat k (k=0..length-1) must equal `{header[15:0], k[15:0]}`.
- **FSM states:**
  - IDLE → BODY on `vld&sop&~eop`.
  - IDLE → IDLE on `vld&sop&eop`; this is a header-only packet and is good only if length==0.
  - BODY → IDLE on `vld&eop`.
  - BODY → DRAIN when beat count exceeds length without `eop`.
  - DRAIN → IDLE on `vld&eop`.
- **Error flag bits:**
  - [0] DEST: header dest ≠ RX_PORT.
  - [1] LEN: `eop` beat index ≠ length, or overrun.
  - [2] DATA: any payload mismatch.
  - [3] SOP: `sop` while in BODY/DRAIN. The current packet is terminated as bad and the new header is processed in the same cycle.
  - [4] ORPHAN: `vld` without `sop` in IDLE. Counted per beat; no FSM change.
  - [5] RDY: `vld` while `ready`==0. The beat is still accepted.
- **Packet termination** (on `eop`, SOP abort, or the header-only case):
  - `pkt_done` pulses.
  - `pkt_ok` = no per-packet error.
  - Exactly one of `pkt_cnt` or `err_cnt` increments.
- Counters saturate and never wrap.
- `clear` and a termination in the same cycle: `clear` wins, and the counters and flags read 0 afterwards.
- Beats with `vld`=0 are ignored regardless of `sop`/`eop`.

## Timing
- Every beat is accepted; the block never back-pressures except through `stall`→`ready`.
- `ready` follows `stall` with 1-cycle latency. The first cycle after `rst` falls, `ready`=1 if `stall`=0.
- `pkt_done`, `pkt_ok`, counters and flags update in the cycle after the terminating beat (1-cycle latency). ORPHAN/RDY flags also update 1 cycle after the offending beat.
- Back-to-back packets, with the next `sop` in the cycle after `eop`, must be handled with no lost beat.
- `rst` asserted mid-packet: FSM returns to IDLE and all outputs return to reset values immediately. The partial packet is not counted.

## Structure
- A shared package/header `rx_check_defs` holds:
  - header field offsets and widths, derived from the `generate_parameter.vh` widths;
  - error-bit indices;
  - FSM state encodings (IDLE/BODY/DRAIN);
  - the payload-pattern function.
- Sub-module `rx_sat_counter` (parameterised width; `inc`, `clr`, `clr` priority) is instantiated for `pkt_cnt` and `err_cnt`.

## Test plan
- RX_PORT=2, header 0x0000_1503 (len 3, pri 5, dest 2, src 0), payloads 0x1503_0000..0x1503_0002 → `pkt_done`&`pkt_ok` 1 cycle after `eop`, `pkt_cnt`=1, `err_flags`=0.
- Same packet with dest=1 (header 0x0000_0D03) → `pkt_ok`=0, `err_flags`[0]=1, `err_cnt`=1, `pkt_cnt`=0.
- len=3 but `eop` on payload beat 1; then a separate len=2 packet whose beat 1 is corrupted to 0x0000_0000 → `err_flags`[1] and [2] set, `err_cnt`=2.
- `sop` mid-packet followed by a valid len-0 header-only packet (`sop`&`eop`, header 0x0000_1000) → first packet bad ([3] set), second good; `pkt_cnt`=1, `err_cnt`=1.
- Two orphan `vld` beats in IDLE; `stall`=1 with one valid packet sent → `err_cnt`=2, the packet still counts good, flags [4] and [5] set, `ready` low 1 cycle after `stall`.
- `clear` in the same cycle as a good `eop`; then `rst` asserted mid-packet → counters read 0, `busy`=0, and `ready`=0 during reset.
